// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - mode encodings, FSM states and default polynomial for the BIST LED engine
package bist_pkg;

    localparam logic [1:0] MODE_RING     = 2'd0;
    localparam logic [1:0] MODE_JOHNSON  = 2'd1;
    localparam logic [1:0] MODE_LFSR     = 2'd2;
    localparam logic [1:0] MODE_SELFTEST = 2'd3;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_ST   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;

endpackage

// File: rtl/bist_tick_gen.sv
// rtl/bist_tick_gen.sv - free-running display-rate divider producing a one-cycle tick
module bist_tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/bist_pattern_engine.sv
// rtl/bist_pattern_engine.sv - ring/Johnson/LFSR LED pattern generator with MISR self-test
module bist_pattern_engine
    import bist_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DIV      = 50_000_000,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
    parameter int               PATTERNS = 1024,
    parameter logic [WIDTH-1:0] GOLDEN   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             hold,
    input  logic             step,
    output logic [WIDTH-1:0] led,
    output logic             done,
    output logic             pass
);

    localparam int               CNT_W    = $clog2(PATTERNS + 1);
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    state_t           state, state_n;
    logic [1:0]       mode_q, mode_q_n;
    logic [WIDTH-1:0] ring, ring_n, john, john_n, lfsr, lfsr_n, misr, misr_n, led_n;
    logic [CNT_W-1:0] pat_cnt, pat_cnt_n;
    logic             done_n, pass_n;
    logic             step_q, step_qq;
    logic             tick, tick_rst, step_rise, mode_chg, adv_run, adv_st;

    function automatic logic [WIDTH-1:0] galois(input logic [WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    // The display divider restarts with every pattern load so ticks stay aligned to the seed.
    assign tick_rst = rst || (state == S_LOAD);

    bist_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (tick_rst),
        .tick (tick)
    );

    assign step_rise = step_q & ~step_qq;
    assign mode_chg  = (mode != mode_q);
    assign adv_run   = (tick & ~hold) | (hold & step_rise);
    assign adv_st    = ~hold | step_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            mode_q  <= '0;
            ring    <= '0;
            john    <= '0;
            lfsr    <= '0;
            misr    <= '0;
            pat_cnt <= '0;
            led     <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            step_q  <= 1'b0;
            step_qq <= 1'b0;
        end else begin
            state   <= state_n;
            mode_q  <= mode_q_n;
            ring    <= ring_n;
            john    <= john_n;
            lfsr    <= lfsr_n;
            misr    <= misr_n;
            pat_cnt <= pat_cnt_n;
            led     <= led_n;
            done    <= done_n;
            pass    <= pass_n;
            step_q  <= step;
            step_qq <= step_q;
        end
    end

    always_comb begin
        state_n   = state;
        mode_q_n  = mode_q;
        ring_n    = ring;
        john_n    = john;
        lfsr_n    = lfsr;
        misr_n    = misr;
        pat_cnt_n = pat_cnt;
        done_n    = done;
        pass_n    = pass;
        led_n     = '0;

        case (state)
            S_LOAD: begin
                ring_n    = WIDTH'(1);
                john_n    = '0;
                lfsr_n    = SEED_EFF;
                misr_n    = '0;
                pat_cnt_n = '0;
                done_n    = 1'b0;
                pass_n    = 1'b0;
                mode_q_n  = mode;
                state_n   = (mode == MODE_SELFTEST) ? S_ST : S_RUN;
            end
            S_RUN: begin
                if (mode_chg) begin
                    state_n = S_LOAD;
                end else if (adv_run) begin
                    ring_n = {ring[WIDTH-2:0], ring[WIDTH-1]};
                    john_n = {john[WIDTH-2:0], ~john[WIDTH-1]};
                    lfsr_n = galois(lfsr);
                end
            end
            S_ST: begin
                if (mode_chg) begin
                    state_n = S_LOAD;
                end else if (adv_st) begin
                    // Fold the pattern currently held, before the LFSR moves on.
                    misr_n    = galois(misr) ^ lfsr;
                    lfsr_n    = galois(lfsr);
                    pat_cnt_n = pat_cnt + CNT_W'(1);
                    if (pat_cnt == CNT_W'(PATTERNS - 1)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        pass_n  = (misr_n == GOLDEN);
                    end
                end
            end
            S_DONE: begin
                if (mode_chg) begin
                    state_n = S_LOAD;
                end
            end
            default: state_n = S_LOAD;
        endcase

        case (state_n)
            S_RUN: begin
                case (mode_q_n)
                    MODE_RING:    led_n = ring_n;
                    MODE_JOHNSON: led_n = john_n;
                    default:      led_n = lfsr_n;
                endcase
            end
            S_ST:    led_n = misr_n;
            S_DONE:  led_n = pass_n ? '1 : misr_n;
            default: led_n = '0;
        endcase
    end

endmodule

// File: tb/tb_bist_pattern_engine.sv
// tb/tb_bist_pattern_engine.sv - randomized and directed bench against a pattern-index reference model
module tb_bist_pattern_engine;

    localparam int          W      = 16;
    localparam int          DIV    = 4;
    localparam int          PAT    = 3;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [15:0] SEED   = 16'h0001;
    localparam logic [15:0] GOLD_A = 16'h5A00;
    localparam logic [15:0] GOLD_B = 16'h5A01;

    localparam int P_LOAD = 0;
    localparam int P_RUN  = 1;
    localparam int P_ST   = 2;
    localparam int P_DONE = 3;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        hold = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] led_a, led_b;
    logic        done_a, pass_a, done_b, pass_b;

    int n_vec = 0;
    int n_err = 0;

    int         ph = P_LOAD;
    int         mk = 0;
    int         mn = 0;
    logic [1:0] mq = 2'd0;
    bit         m_done = 0, m_pass_a = 0, m_pass_b = 0;
    bit         rise_prev = 0, step_prev = 0;

    always #5 clk = ~clk;

    bist_pattern_engine #(.WIDTH(W), .DIV(DIV), .TAPS(TAPS), .SEED(SEED), .PATTERNS(PAT), .GOLDEN(GOLD_A)) u_dut_a (
        .clk(clk), .rst(rst), .mode(mode), .hold(hold), .step(step),
        .led(led_a), .done(done_a), .pass(pass_a)
    );

    bist_pattern_engine #(.WIDTH(W), .DIV(DIV), .TAPS(TAPS), .SEED(SEED), .PATTERNS(PAT), .GOLDEN(GOLD_B)) u_dut_b (
        .clk(clk), .rst(rst), .mode(mode), .hold(hold), .step(step),
        .led(led_b), .done(done_b), .pass(pass_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] v = SEED;
        for (int i = 0; i < k; i++) v = galois(v);
        return v;
    endfunction

    function automatic logic [15:0] sig_at(input int k);
        logic [15:0] s = 16'h0000;
        logic [15:0] l = SEED;
        for (int i = 0; i < k; i++) begin
            s = galois(s) ^ l;
            l = galois(l);
        end
        return s;
    endfunction

    function automatic logic [15:0] ring_at(input int k);
        logic [15:0] one = 16'h0001;
        return one << (k % W);
    endfunction

    function automatic logic [15:0] john_at(input int k);
        int          j   = k % (2 * W);
        logic [15:0] all = 16'hFFFF;
        if (j <= W) return 16'((32'd1 << j) - 32'd1);
        return all << (j - W);
    endfunction

    function automatic logic [15:0] exp_led(input bit pass_x);
        case (ph)
            P_LOAD: return 16'h0000;
            P_RUN:  return (mq == 2'd0) ? ring_at(mk) : (mq == 2'd1) ? john_at(mk) : lfsr_at(mk);
            P_ST:   return sig_at(mk);
            default: return pass_x ? 16'hFFFF : sig_at(PAT);
        endcase
    endfunction

    // mk counts advances since the last load; tick edges fall every DIV edges after the load edge.
    task automatic model_edge();
        bit rise_now;
        bit apply;
        rise_now = step && !step_prev;
        apply    = rise_prev;
        if (rst) begin
            ph = P_LOAD; mk = 0; m_done = 0; m_pass_a = 0; m_pass_b = 0;
            rise_now = 0;
        end else begin
            case (ph)
                P_LOAD: begin
                    mq = mode; mk = 0; mn = 0; m_done = 0; m_pass_a = 0; m_pass_b = 0;
                    ph = (mode == 2'd3) ? P_ST : P_RUN;
                end
                P_RUN: begin
                    mn++;
                    if (mode != mq) ph = P_LOAD;
                    else if ((mn % DIV == 0 && !hold) || (hold && apply)) mk++;
                end
                P_ST: begin
                    if (mode != mq) ph = P_LOAD;
                    else if (!hold || apply) begin
                        mk++;
                        if (mk == PAT) begin
                            ph = P_DONE; m_done = 1;
                            m_pass_a = (sig_at(PAT) == GOLD_A);
                            m_pass_b = (sig_at(PAT) == GOLD_B);
                        end
                    end
                end
                default: if (mode != mq) ph = P_LOAD;
            endcase
        end
        rise_prev = rise_now;
        step_prev = rst ? 1'b0 : step;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("led_a", 32'(led_a), 32'(exp_led(m_pass_a)));
        check("led_b", 32'(led_b), 32'(exp_led(m_pass_b)));
        check("done_a", 32'(done_a), 32'(m_done));
        check("pass_a", 32'(pass_a), 32'(m_pass_a));
        check("done_b", 32'(done_b), 32'(m_done));
        check("pass_b", 32'(pass_b), 32'(m_pass_b));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int len;
        int hsel;

        run(3);
        check("reset_led", 32'(led_a), 32'h0);
        rst = 1'b0;

        run(70);
        mode = 2'd1;
        run(140);

        mode = 2'd2;
        run(14);
        check("lfsr_third", 32'(led_a), 32'h2D00);
        hold = 1'b1;
        run(20);
        check("hold_freeze", 32'(led_a), 32'h2D00);
        step = 1'b1; run(2);
        step = 1'b0; run(2);
        check("step_one", 32'(led_a), 32'h1680);
        step = 1'b1; run(2);
        step = 1'b0; run(3);
        check("step_two", 32'(led_a), 32'h0B40);
        hold = 1'b0;

        mode = 2'd3;
        run(8);
        check("st_done", 32'(done_a), 32'h1);
        check("st_pass_good", 32'(pass_a), 32'h1);
        check("st_led_good", 32'(led_a), 32'hFFFF);
        check("st_pass_bad", 32'(pass_b), 32'h0);
        check("st_led_bad", 32'(led_b), 32'h5A00);

        mode = 2'd0;
        run(13);
        mode = 2'd2;
        cyc();
        check("chg_load", 32'(led_a), 32'h0);
        cyc();
        check("chg_seed", 32'(led_a), 32'h0001);

        mode = 2'd3;
        run(3);
        rst = 1'b1;
        cyc();
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_led", 32'(led_a), 32'h0);
        rst = 1'b0;
        run(PAT);
        check("rerun_not_yet", 32'(done_a), 32'h0);
        cyc();
        check("rerun_done", 32'(done_a), 32'h1);

        for (int s = 0; s < 60; s++) begin
            mode = 2'($urandom_range(0, 3));
            len  = $urandom_range(5, 80);
            hsel = $urandom_range(0, 2);
            for (int c = 0; c < len; c++) begin
                hold = (hsel == 1) ? 1'b1 : (hsel == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
                step = 1'($urandom_range(0, 1));
                rst  = ($urandom_range(0, 199) == 0);
                cyc();
            end
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
